nmp_axil_job_master: RTL and testbench



---
 rtl/nmp_axil_job_master.sv | 185 ++++++++++++++++++
 tb/tb_nmp_axil_job_master.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nmp_axil_job_master.sv
// nmp_axil_job_master: AXI4-Lite master that runs one NMP vector-add job per start pulse
module nmp_axil_job_master #(
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int MAX_POLLS = 1024,
  parameter int POLL_GAP = 4,
  localparam int C_AXI_DATA_WIDTH = 32
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic                          i_start,
  input  logic [31:0]                   i_veca,
  input  logic [31:0]                   i_vecb,
  input  logic [31:0]                   i_vecr,
  input  logic [31:0]                   i_len,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_error,
  output logic [1:0]                    o_err_code,
  output logic [15:0]                   o_poll_count,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP
);
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] A_OP   = AW'(BASE_ADDR);
  localparam logic [AW-1:0] A_STAT = AW'(BASE_ADDR + 32'h08);
  localparam logic [AW-1:0] A_VECA = AW'(BASE_ADDR + 32'h14);
  localparam logic [AW-1:0] A_VECB = AW'(BASE_ADDR + 32'h18);
  localparam logic [AW-1:0] A_VECR = AW'(BASE_ADDR + 32'h1C);
  localparam logic [AW-1:0] A_LEN  = AW'(BASE_ADDR + 32'h20);

  typedef enum logic [3:0] {IDLE, WR_VECA, WR_VECB, WR_VECR, WR_LEN, WR_OP,
                            POLL_AR, POLL_R, POLL_WAIT, WR_CLR, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     veca_q, veca_d, vecb_q, vecb_d, vecr_q, vecr_d, len_q, len_d, wdata_q, wdata_d;
  logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d, b_done_q, b_done_d;
  logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [15:0]     poll_cnt_q, poll_cnt_d, gap_q, gap_d;
  logic            unused_rdata;

  assign unused_rdata = ^M_AXI_RDATA[C_AXI_DATA_WIDTH-1:1];

  // State and every registered output; reset abandons any job in flight
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
      {veca_q, vecb_q, vecr_q, len_q, wdata_q} <= '0;
      {awaddr_q, araddr_q} <= '0;
      {awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q} <= '0;
      {aw_done_q, w_done_q, b_done_q} <= '0;
      {busy_q, done_q, error_q, err_code_q} <= '0;
      {poll_cnt_q, gap_q} <= '0;
    end else begin
      state_q <= state_d;
      {veca_q, vecb_q, vecr_q, len_q, wdata_q} <= {veca_d, vecb_d, vecr_d, len_d, wdata_d};
      {awaddr_q, araddr_q} <= {awaddr_d, araddr_d};
      {awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q} <= {awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d};
      {aw_done_q, w_done_q, b_done_q} <= {aw_done_d, w_done_d, b_done_d};
      {busy_q, done_q, error_q, err_code_q} <= {busy_d, done_d, error_d, err_code_d};
      {poll_cnt_q, gap_q} <= {poll_cnt_d, gap_d};
    end
  end

  // Job sequencing; a new AXI request is launched on the edge that enters its state
  always_comb begin
    state_d    = state_q;
    veca_d     = veca_q;
    vecb_d     = vecb_q;
    vecr_d     = vecr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    awvalid_d  = awvalid_q & ~M_AXI_AWREADY;
    wvalid_d   = wvalid_q & ~M_AXI_WREADY;
    bready_d   = bready_q & ~M_AXI_BVALID;
    arvalid_d  = arvalid_q & ~M_AXI_ARREADY;
    rready_d   = rready_q & ~M_AXI_RVALID;
    aw_done_d  = aw_done_q | (awvalid_q & M_AXI_AWREADY);
    w_done_d   = w_done_q | (wvalid_q & M_AXI_WREADY);
    b_done_d   = b_done_q | (bready_q & M_AXI_BVALID);
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    err_code_d = err_code_q;
    poll_cnt_d = poll_cnt_q;
    gap_d      = gap_q;
    case (state_q)
      IDLE: if (i_start) begin
        {veca_d, vecb_d, vecr_d, len_d} = {i_veca, i_vecb, i_vecr, i_len};
        {error_d, err_code_d, poll_cnt_d} = '0;
        busy_d  = 1'b1;
        state_d = WR_VECA;
      end
      WR_VECA, WR_VECB, WR_VECR, WR_LEN, WR_OP, WR_CLR: begin
        if (state_q != WR_CLR && bready_q && M_AXI_BVALID && M_AXI_BRESP != 2'b00) err_code_d = 2'b01;
        if (aw_done_d && w_done_d && b_done_d) begin
          state_d = state_q == WR_CLR ? DONE : err_code_d != 2'b00 ? WR_CLR : state_t'(state_q + 4'd1);
          done_d  = state_q == WR_CLR;
          error_d = state_q == WR_CLR ? err_code_q != 2'b00 : error_q;
        end
      end
      POLL_AR: if (arvalid_q && M_AXI_ARREADY) begin
        rready_d   = 1'b1;
        poll_cnt_d = poll_cnt_q + {15'd0, poll_cnt_q != 16'hFFFF};
        state_d    = POLL_R;
      end
      POLL_R: if (rready_q && M_AXI_RVALID) begin
        gap_d = '0;
        if (M_AXI_RRESP != 2'b00) begin
          err_code_d = 2'b10;
          state_d    = WR_CLR;
        end else if (M_AXI_RDATA[0]) begin
          state_d = WR_CLR;
        end else if (int'(poll_cnt_q) == MAX_POLLS) begin
          err_code_d = 2'b11;
          state_d    = WR_CLR;
        end else begin
          state_d = POLL_GAP == 0 ? POLL_AR : POLL_WAIT;
        end
      end
      POLL_WAIT: begin
        gap_d   = gap_q + 16'd1;
        state_d = int'(gap_q) >= POLL_GAP - 1 ? POLL_AR : POLL_WAIT;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q && state_d inside {WR_VECA, WR_VECB, WR_VECR, WR_LEN, WR_OP, WR_CLR}) begin
      {awvalid_d, wvalid_d, bready_d} = 3'b111;
      {aw_done_d, w_done_d, b_done_d} = 3'b000;
      awaddr_d = state_d == WR_VECA ? A_VECA : state_d == WR_VECB ? A_VECB :
                 state_d == WR_VECR ? A_VECR : state_d == WR_LEN ? A_LEN : A_OP;
      wdata_d  = state_d == WR_VECA ? veca_d : state_d == WR_VECB ? vecb_q :
                 state_d == WR_VECR ? vecr_q : state_d == WR_LEN ? len_q :
                 state_d == WR_OP ? 32'h3 : 32'h0;
    end
    if (state_d == POLL_AR && state_q != POLL_AR) begin
      arvalid_d = 1'b1;
      araddr_d  = A_STAT;
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = error_q;
  assign o_err_code    = err_code_q;
  assign o_poll_count  = poll_cnt_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_nmp_axil_job_master.sv
// tb_nmp_axil_job_master: randomized jobs against an AXI-Lite slave model and a transaction-list reference
module tb_nmp_axil_job_master;
  localparam int MAXP = 5;
  localparam int GAP  = 4;
  localparam logic [31:0] BASE = 32'h1F0;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_veca = '0, i_vecb = '0, i_vecr = '0, i_len = '0;
  logic        o_busy, o_done, o_error;
  logic [1:0]  o_err_code;
  logic [15:0] o_poll_count;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic [31:0] wdata, rdata = '0;
  logic [3:0]  wstrb;
  logic [1:0]  bresp = '0, rresp = '0;

  nmp_axil_job_master #(.C_AXI_ADDR_WIDTH(8), .BASE_ADDR(BASE), .MAX_POLLS(MAXP), .POLL_GAP(GAP)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .i_start(i_start), .i_veca(i_veca), .i_vecb(i_vecb), .i_vecr(i_vecr), .i_len(i_len),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_err_code(o_err_code), .o_poll_count(o_poll_count),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
  );

  always #5 clk = ~clk;

  int checks = 0, fails = 0;
  bit bp = 1'b0;
  int bad_wr = -1, done_after = 0, rbad_at = 0, wr_k = 0, rd_k = 0;
  int proto_bad = 0, gap_bad = 0, cyc = 0, r_cyc = -1;
  logic [63:0] act_q[$], exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input bit rd, input int off, input logic [31:0] d);
    return {23'd0, rd, 8'(BASE + 32'(off)), d};
  endfunction

  // Reference: the ordered list of transactions a job must produce, plus its final error and poll count
  task automatic build_exp(input logic [31:0] a, b, r, l, output int e_err, output int e_polls);
    int offs[5] = '{'h14, 'h18, 'h1C, 'h20, 'h00};
    logic [31:0] v[5];
    bit fin = 1'b0;
    v = '{a, b, r, l, 32'd3};
    exp_q.delete();
    e_err = 0;
    e_polls = 0;
    for (int i = 0; i < 5 && e_err == 0; i++) begin
      exp_q.push_back(ent(1'b0, offs[i], v[i]));
      if (i == bad_wr) e_err = 1;
    end
    for (int p = 1; p <= MAXP && e_err == 0 && !fin; p++) begin
      exp_q.push_back(ent(1'b1, 'h08, 32'd0));
      e_polls = p;
      if (p == rbad_at) e_err = 2;
      else if (p == done_after) fin = 1'b1;
      else if (p == MAXP) e_err = 3;
    end
    exp_q.push_back(ent(1'b0, 'h00, 32'd0));
  endtask

  // AXI-Lite slave: readies, B and R beats decided at the falling edge, handshakes logged for the next rising edge
  initial begin : slave
    bit aw_got = 0, w_got = 0, ar_got = 0, hs_b = 0, hs_r = 0, p_aw = 0, p_w = 0, p_ar = 0, arv_prev = 0;
    logic [7:0] cap_a = '0, prev_aw = '0, prev_ar = '0;
    logic [31:0] cap_d = '0, prev_w = '0;
    int b_dly = 0, r_dly = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        {aw_got, w_got, ar_got, hs_b, hs_r, p_aw, p_w, p_ar, arv_prev} = '0;
        {awready, wready, arready, bvalid, rvalid} = '0;
        b_dly = 0;
        r_dly = 0;
      end else begin
        if ((p_aw && !(awvalid && awaddr == prev_aw)) || (p_w && !(wvalid && wdata == prev_w)) ||
            (p_ar && !(arvalid && araddr == prev_ar))) proto_bad++;
        if (hs_b) {bvalid, aw_got, w_got} = '0;
        if (hs_r) rvalid = 1'b0;
        if ((awvalid && arvalid) || (aw_got && awvalid) || (w_got && wvalid) ||
            ((ar_got || rvalid) && (arvalid || awvalid))) proto_bad++;
        if (arvalid && !arv_prev && r_cyc >= 0 && cyc - r_cyc - 1 != GAP) gap_bad++;
        arv_prev = arvalid;
        if (aw_got && w_got && !bvalid) begin
          if (b_dly == 0) begin
            bvalid = 1'b1;
            bresp = wr_k == bad_wr ? 2'($urandom_range(1, 3)) : 2'b00;
          end else b_dly--;
        end
        if (ar_got && !rvalid) begin
          if (r_dly == 0) begin
            rvalid = 1'b1;
            ar_got = 1'b0;
            rresp = rd_k == rbad_at ? 2'($urandom_range(1, 3)) : 2'b00;
            rdata = {31'($urandom), rd_k == done_after};
            r_dly = bp ? $urandom_range(0, 3) : 0;
          end else r_dly--;
        end
        awready = !aw_got && (!bp || $urandom_range(0, 2) == 0);
        wready  = !w_got && (!bp || $urandom_range(0, 2) == 0);
        arready = !ar_got && !rvalid && (!bp || $urandom_range(0, 2) == 0);
        p_aw = awvalid && !awready;
        p_w  = wvalid && !wready;
        p_ar = arvalid && !arready;
        prev_aw = awaddr;
        prev_w  = wdata;
        prev_ar = araddr;
        if (awvalid && awready) begin
          aw_got = 1'b1;
          cap_a = awaddr;
        end
        if (wvalid && wready) begin
          w_got = 1'b1;
          cap_d = wdata;
        end
        if (arvalid && arready) begin
          ar_got = 1'b1;
          rd_k++;
          act_q.push_back({23'd0, 1'b1, araddr, 32'd0});
        end
        hs_b = bready && bvalid;
        if (hs_b) begin
          act_q.push_back({23'd0, 1'b0, cap_a, cap_d});
          wr_k++;
          b_dly = bp ? $urandom_range(0, 3) : 0;
        end
        hs_r = rready && rvalid;
        if (hs_r) r_cyc = cyc;
      end
    end
  end

  task automatic run_job(input logic [31:0] a, b, r, l, input bit bpi, input int bw, da, rb, input bit noise);
    int e_err, e_polls, n, dn, m;
    bp = bpi;
    bad_wr = bw;
    done_after = da;
    rbad_at = rb;
    wr_k = 0;
    rd_k = 0;
    r_cyc = -1;
    act_q.delete();
    build_exp(a, b, r, l, e_err, e_polls);
    @(negedge clk);
    {i_veca, i_vecb, i_vecr, i_len} = {a, b, r, l};
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("busy_rise", o_busy, 1);
    check("accept_clr", {o_error, o_err_code, o_poll_count}, 0);
    dn = 0;
    n = 0;
    while (n < 3000 && !(dn > 0 && !o_busy)) begin
      @(negedge clk);
      n++;
      i_start = 1'b0;
      if (o_done) begin
        dn++;
        check("error", o_error, e_err != 0);
        check("err_code", o_err_code, e_err);
        check("poll_count", o_poll_count, e_polls);
      end else if (dn > 0) check("busy_fall", o_busy, 0);
      if (noise && o_busy && $urandom_range(0, 5) == 0) begin
        i_start = 1'b1;
        {i_veca, i_vecb, i_vecr, i_len} = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    i_start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    check("done_pulses", dn, 1);
    check("err_hold", {o_error, o_err_code}, {e_err != 0, 2'(e_err)});
    check("n_txn", act_q.size(), exp_q.size());
    m = act_q.size() < exp_q.size() ? act_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) check($sformatf("txn%0d", i), act_q[i], exp_q[i]);
  endtask

  initial begin
    int n, dn;
    repeat (3) @(negedge clk);
    check("rst_valid", {awvalid, wvalid, bready, arvalid, rready, o_busy, o_done, o_error}, 0);
    check("rst_regs", {o_err_code, o_poll_count, awaddr, araddr, wdata}, 0);
    rst_n = 1'b1;
    run_job(32'h10, 32'h20, 32'h30, 32'd4, 0, -1, 3, 0, 0);
    check("const_prot_strb", {awprot, arprot, wstrb}, 10'h00F);
    run_job(32'h10, 32'h20, 32'h30, 32'd4, 1, -1, 3, 0, 0);
    run_job(32'h10, 32'h20, 32'h30, 32'd4, 0, 0, 3, 0, 0);
    run_job(32'h10, 32'h20, 32'h30, 32'd4, 1, -1, 0, 0, 0);
    run_job(32'h11, 32'h22, 32'h33, 32'd8, 0, -1, MAXP, 0, 0);
    run_job(32'h11, 32'h22, 32'h33, 32'd8, 0, -1, 3, 2, 0);
    run_job(32'h11, 32'h22, 32'h33, 32'd8, 0, 5, 1, 0, 0);
    run_job(32'hA5A5, 32'h5A5A, 32'hFFFF0000, 32'd16, 1, -1, 4, 0, 1);
    bp = 0;
    bad_wr = -1;
    done_after = 0;
    rbad_at = 0;
    wr_k = 0;
    rd_k = 0;
    r_cyc = -1;
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    n = 0;
    while (!arvalid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ar_seen", arvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_async_rst", arvalid, 0);
    check("busy_async_rst", o_busy, 0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    check("no_done_after_rst", dn, 0);
    rst_n = 1'b1;
    run_job(32'h10, 32'h20, 32'h30, 32'd4, 0, -1, 3, 0, 0);
    for (int j = 0; j < 30; j++)
      run_job($urandom, $urandom, $urandom, $urandom, 1'($urandom), $urandom_range(0, 3) == 0 ? $urandom_range(0, 5) : -1,
              $urandom_range(0, 6), $urandom_range(0, 4) == 0 ? $urandom_range(1, 5) : 0, 1'($urandom));
    check("protocol", proto_bad, 0);
    check("poll_gap", gap_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
